// File: rtl/issue_dispatch_unit_pkg.sv
// Shared issue-queue entry layout and packing helper for dispatch and the issue queue.
// Fields are packed MSB-first: op, has_imm, imm, src1, src1ready, src2, src2ready,
// shift, regwrite, dest, memwrite, memwritedata, memread.
package issue_dispatch_unit_pkg;

  localparam int unsigned IQ_NUM_PHYS_REGS = 64;
  localparam int unsigned IQ_LOG_PHYS      = $clog2(IQ_NUM_PHYS_REGS);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned DATA_W  = 32;

  // LSB offsets, built up from memread at bit 0
  localparam int unsigned MEMREAD_OFF      = 0;
  localparam int unsigned MEMWRITEDATA_OFF = MEMREAD_OFF + 1;
  localparam int unsigned MEMWRITE_OFF     = MEMWRITEDATA_OFF + DATA_W;
  localparam int unsigned DEST_OFF         = MEMWRITE_OFF + 1;
  localparam int unsigned REGWRITE_OFF     = DEST_OFF + IQ_LOG_PHYS;
  localparam int unsigned SHIFT_OFF        = REGWRITE_OFF + 1;
  localparam int unsigned SRC2READY_OFF    = SHIFT_OFF + SHIFT_W;
  localparam int unsigned SRC2_OFF         = SRC2READY_OFF + 1;
  localparam int unsigned SRC1READY_OFF    = SRC2_OFF + IQ_LOG_PHYS;
  localparam int unsigned SRC1_OFF         = SRC1READY_OFF + 1;
  localparam int unsigned IMM_OFF          = SRC1_OFF + IQ_LOG_PHYS;
  localparam int unsigned HAS_IMM_OFF      = IMM_OFF + IMM_W;
  localparam int unsigned OP_OFF           = HAS_IMM_OFF + 1;

  localparam int unsigned ISSUE_QUEUE_ENTRY_BITS = OP_OFF + OP_W;

  function automatic logic [ISSUE_QUEUE_ENTRY_BITS-1:0] pack_entry(
    input logic [OP_W-1:0]        op,
    input logic                   has_imm,
    input logic [IMM_W-1:0]       imm,
    input logic [IQ_LOG_PHYS-1:0] src1,
    input logic                   src1ready,
    input logic [IQ_LOG_PHYS-1:0] src2,
    input logic                   src2ready,
    input logic [SHIFT_W-1:0]     shift,
    input logic                   regwrite,
    input logic [IQ_LOG_PHYS-1:0] dest,
    input logic                   memwrite,
    input logic [DATA_W-1:0]      memwritedata,
    input logic                   memread
  );
    return {op, has_imm, imm, src1, src1ready, src2, src2ready,
            shift, regwrite, dest, memwrite, memwritedata, memread};
  endfunction

endpackage

// File: rtl/issue_dispatch_unit_phys_busy_table.sv
// Physical-register busy bits: one set port, one clear port, flush-clear, two read ports.
module phys_busy_table #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  localparam int unsigned LOG_PHYS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                flush,
  input  logic                set_en,
  input  logic [LOG_PHYS-1:0] set_reg,
  input  logic                clr_en,
  input  logic [LOG_PHYS-1:0] clr_reg,
  input  logic [LOG_PHYS-1:0] rd_reg_a,
  output logic                busy_a,
  input  logic [LOG_PHYS-1:0] rd_reg_b,
  output logic                busy_b
);

  logic [NUM_PHYS_REGS-1:0] busy_q;
  logic [NUM_PHYS_REGS-1:0] busy_d;

  // Next busy vector: clear first so a same-register set wins
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
  end

  // Busy register with async reset and synchronous flush-clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)     busy_q <= '0;
    else if (flush) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_reg_a];
  assign busy_b = busy_q[rd_reg_b];

endmodule

// File: rtl/issue_dispatch_unit.sv
// Dispatch stage: in-order buffer between rename and the issue queue.
// Optional zero-latency bypass on an empty buffer: define ISSUE_DISPATCH_BYPASS_EN.
module issue_dispatch_unit
  import issue_dispatch_unit_pkg::*;
#(
  parameter int unsigned NUM_PHYS_REGS  = 64,
  parameter int unsigned DISPATCH_DEPTH = 4,
  localparam int unsigned LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              Flush_IN,
  input  logic                              Rename_Valid_IN,
  output logic                              Rename_Ready_OUT,
  input  logic [5:0]                        Op_IN,
  input  logic                              HasImm_IN,
  input  logic [31:0]                       Imm_IN,
  input  logic [LOG_PHYS-1:0]               Src1_IN,
  input  logic [LOG_PHYS-1:0]               Src2_IN,
  input  logic [4:0]                        Shift_IN,
  input  logic                              RegWrite_IN,
  input  logic [LOG_PHYS-1:0]               Dest_IN,
  input  logic                              MemWrite_IN,
  input  logic [31:0]                       MemWriteData_IN,
  input  logic                              MemRead_IN,
  input  logic                              WbValid_IN,
  input  logic [LOG_PHYS-1:0]               WbReg_IN,
  input  logic                              IQFull_IN,
  output logic                              Enqueue_OUT,
  output logic [ISSUE_QUEUE_ENTRY_BITS-1:0] IssueQueueEntry_OUT,
  output logic                              ReadyUpdate_OUT,
  output logic [LOG_PHYS-1:0]               ReadyRegister_OUT
);

  localparam int unsigned IDX_W = $clog2(DISPATCH_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]                  head_q, tail_q;
  logic [ISSUE_QUEUE_ENTRY_BITS-1:0] buf_q [DISPATCH_DEPTH];
  logic [ISSUE_QUEUE_ENTRY_BITS-1:0] new_entry, head_entry;
  logic empty, full, accept, write_buf, deq, bypass_take;
  logic busy1, busy2, src1_rdy, src2_rdy, set_en;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);

  assign Rename_Ready_OUT = !full && !Flush_IN;
  assign accept           = Rename_Valid_IN && Rename_Ready_OUT;

`ifdef ISSUE_DISPATCH_BYPASS_EN
  assign bypass_take = empty && !IQFull_IN && Rename_Valid_IN && !Flush_IN;
`else
  assign bypass_take = 1'b0;
`endif

  assign write_buf = accept && !bypass_take;
  assign deq       = !empty && !IQFull_IN && !Flush_IN;
  assign set_en    = accept && RegWrite_IN && (Dest_IN != '0);

  phys_busy_table #(.NUM_PHYS_REGS(NUM_PHYS_REGS)) u_busy (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (Flush_IN),
    .set_en   (set_en),
    .set_reg  (Dest_IN),
    .clr_en   (WbValid_IN),
    .clr_reg  (WbReg_IN),
    .rd_reg_a (Src1_IN),
    .busy_a   (busy1),
    .rd_reg_b (Src2_IN),
    .busy_b   (busy2)
  );

  assign src1_rdy = (Src1_IN == '0) || !busy1 || (WbValid_IN && (WbReg_IN == Src1_IN));
  assign src2_rdy = (Src2_IN == '0) || !busy2 || (WbValid_IN && (WbReg_IN == Src2_IN));

  assign new_entry = pack_entry(Op_IN, HasImm_IN, Imm_IN, Src1_IN, src1_rdy, Src2_IN, src2_rdy,
                                Shift_IN, RegWrite_IN, Dest_IN, MemWrite_IN, MemWriteData_IN,
                                MemRead_IN);

  // Head entry with current-cycle wakeup folded in, bypass mux and enqueue request
  always_comb begin
    head_entry = buf_q[head_q[IDX_W-1:0]];
    if (WbValid_IN && (head_entry[SRC1_OFF +: IQ_LOG_PHYS] == WbReg_IN))
      head_entry[SRC1READY_OFF] = 1'b1;
    if (WbValid_IN && (head_entry[SRC2_OFF +: IQ_LOG_PHYS] == WbReg_IN))
      head_entry[SRC2READY_OFF] = 1'b1;
    IssueQueueEntry_OUT = bypass_take ? new_entry : head_entry;
    Enqueue_OUT         = bypass_take || deq;
  end

  assign ReadyUpdate_OUT   = WbValid_IN;
  assign ReadyRegister_OUT = WbReg_IN;

  // Buffer storage and pointers; wakeups applied to all slots, then the tail write overrides
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DISPATCH_DEPTH; i++) buf_q[i] <= '0;
    end else if (Flush_IN) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (WbValid_IN) begin
        for (int unsigned i = 0; i < DISPATCH_DEPTH; i++) begin
          if (buf_q[i][SRC1_OFF +: IQ_LOG_PHYS] == WbReg_IN) buf_q[i][SRC1READY_OFF] <= 1'b1;
          if (buf_q[i][SRC2_OFF +: IQ_LOG_PHYS] == WbReg_IN) buf_q[i][SRC2READY_OFF] <= 1'b1;
        end
      end
      if (write_buf) begin
        buf_q[tail_q[IDX_W-1:0]] <= new_entry;
        tail_q <= tail_q + 1'b1;
      end
      if (deq) head_q <= head_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Directed, table-driven bench for issue_dispatch_unit (default 64 regs, depth 4).
module tb_issue_dispatch_unit;

  localparam int EB = 99;

  logic        CLK, RESET, Flush_IN, Rename_Valid_IN, Rename_Ready_OUT;
  logic [5:0]  Op_IN;
  logic        HasImm_IN;
  logic [31:0] Imm_IN;
  logic [5:0]  Src1_IN, Src2_IN;
  logic [4:0]  Shift_IN;
  logic        RegWrite_IN;
  logic [5:0]  Dest_IN;
  logic        MemWrite_IN;
  logic [31:0] MemWriteData_IN;
  logic        MemRead_IN, WbValid_IN;
  logic [5:0]  WbReg_IN;
  logic        IQFull_IN, Enqueue_OUT, ReadyUpdate_OUT;
  logic [EB-1:0] IssueQueueEntry_OUT;
  logic [5:0]  ReadyRegister_OUT;

  int n_checks = 0;
  int n_errors = 0;

  issue_dispatch_unit #(.NUM_PHYS_REGS(64), .DISPATCH_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .Flush_IN(Flush_IN),
    .Rename_Valid_IN(Rename_Valid_IN), .Rename_Ready_OUT(Rename_Ready_OUT),
    .Op_IN(Op_IN), .HasImm_IN(HasImm_IN), .Imm_IN(Imm_IN),
    .Src1_IN(Src1_IN), .Src2_IN(Src2_IN), .Shift_IN(Shift_IN),
    .RegWrite_IN(RegWrite_IN), .Dest_IN(Dest_IN), .MemWrite_IN(MemWrite_IN),
    .MemWriteData_IN(MemWriteData_IN), .MemRead_IN(MemRead_IN),
    .WbValid_IN(WbValid_IN), .WbReg_IN(WbReg_IN), .IQFull_IN(IQFull_IN),
    .Enqueue_OUT(Enqueue_OUT), .IssueQueueEntry_OUT(IssueQueueEntry_OUT),
    .ReadyUpdate_OUT(ReadyUpdate_OUT), .ReadyRegister_OUT(ReadyRegister_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       flush, rv;
    logic [5:0] op, s1, s2;
    logic       rw;
    logic [5:0] d;
    logic       wbv;
    logic [5:0] wbr;
    logic       iqf;
    logic       e_rr, e_enq, chk;
    logic [5:0] e_op;
    logic       e_s1r, e_s2r;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic flush, input logic rv, input logic [5:0] op,
                              input logic [5:0] s1, input logic [5:0] s2, input logic rw,
                              input logic [5:0] d, input logic wbv, input logic [5:0] wbr,
                              input logic iqf, input logic e_rr, input logic e_enq,
                              input logic chk, input logic [5:0] e_op, input logic e_s1r,
                              input logic e_s2r);
    vec_t v;
    v.flush = flush; v.rv = rv; v.op = op; v.s1 = s1; v.s2 = s2; v.rw = rw; v.d = d;
    v.wbv = wbv; v.wbr = wbr; v.iqf = iqf; v.e_rr = e_rr; v.e_enq = e_enq; v.chk = chk;
    v.e_op = e_op; v.e_s1r = e_s1r; v.e_s2r = e_s2r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    Flush_IN = 0; Rename_Valid_IN = 0; Op_IN = '0; HasImm_IN = 0; Imm_IN = '0;
    Src1_IN = '0; Src2_IN = '0; Shift_IN = '0; RegWrite_IN = 0; Dest_IN = '0;
    MemWrite_IN = 0; MemWriteData_IN = '0; MemRead_IN = 0; WbValid_IN = 0;
    WbReg_IN = '0; IQFull_IN = 0;
  endtask

  logic [EB-1:0] exp_entry;

  initial begin
    RESET = 1'b0;
    idle();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // cycle-by-cycle table; inputs held for one cycle, outputs sampled 2ns after negedge
    vt[0]  = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,0,0, 0,0,0);
    vt[1]  = mk(0,1, 1, 5, 0,1, 9,0, 0,1, 1,0,0, 0,0,0);
    vt[2]  = mk(0,1, 2, 9, 0,0, 0,0, 0,0, 1,1,1, 1,1,1);
    vt[3]  = mk(0,0, 0, 0, 0,0, 0,0, 0,1, 1,0,1, 2,0,1);
    vt[4]  = mk(0,0, 0, 0, 0,0, 0,1, 9,1, 1,0,1, 2,1,1);
    vt[5]  = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,1,1, 2,1,1);
    vt[6]  = mk(0,1, 3, 0, 0,1,12,1,12,1, 1,0,0, 0,0,0);
    vt[7]  = mk(0,1, 4,12,12,0, 0,0, 0,1, 1,0,1, 3,1,1);
    vt[8]  = mk(0,1, 5, 3, 4,0, 0,0, 0,1, 1,0,1, 3,1,1);
    vt[9]  = mk(0,1, 6, 0, 0,0, 0,0, 0,1, 1,0,1, 3,1,1);
    vt[10] = mk(0,1, 7, 0, 0,0, 0,0, 0,1, 0,0,1, 3,1,1);
    vt[11] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 0,1,1, 3,1,1);
    vt[12] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,1,1, 4,0,0);
    vt[13] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,1,1, 5,1,1);
    vt[14] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,1,1, 6,1,1);
    vt[15] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,0,0, 0,0,0);
    vt[16] = mk(0,1, 8, 0, 0,1,20,0, 0,1, 1,0,0, 0,0,0);
    vt[17] = mk(0,1, 9,20, 0,0, 0,0, 0,1, 1,0,1, 8,1,1);
    vt[18] = mk(0,1,10, 0, 0,0, 0,0, 0,1, 1,0,1, 8,1,1);
    vt[19] = mk(1,1,11, 0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0);
    vt[20] = mk(0,1,12,20, 0,0, 0,0, 0,1, 1,0,0, 0,0,0);
    vt[21] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,1,1,12,1,1);
    vt[22] = mk(0,0, 0, 0, 0,0, 0,0, 0,0, 1,0,0, 0,0,0);

    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      idle();
      Flush_IN = vt[i].flush; Rename_Valid_IN = vt[i].rv; Op_IN = vt[i].op;
      Src1_IN = vt[i].s1; Src2_IN = vt[i].s2; RegWrite_IN = vt[i].rw; Dest_IN = vt[i].d;
      WbValid_IN = vt[i].wbv; WbReg_IN = vt[i].wbr; IQFull_IN = vt[i].iqf;
      #2;
      chk($sformatf("row%0d_rename_ready", i), 128'(Rename_Ready_OUT), 128'(vt[i].e_rr));
      chk($sformatf("row%0d_enqueue", i), 128'(Enqueue_OUT), 128'(vt[i].e_enq));
      chk($sformatf("row%0d_ready_update", i), 128'(ReadyUpdate_OUT), 128'(vt[i].wbv));
      if (vt[i].wbv)
        chk($sformatf("row%0d_ready_reg", i), 128'(ReadyRegister_OUT), 128'(vt[i].wbr));
      if (vt[i].chk) begin
        chk($sformatf("row%0d_op", i), 128'(IssueQueueEntry_OUT[98:93]), 128'(vt[i].e_op));
        chk($sformatf("row%0d_src1ready", i), 128'(IssueQueueEntry_OUT[53]), 128'(vt[i].e_s1r));
        chk($sformatf("row%0d_src2ready", i), 128'(IssueQueueEntry_OUT[46]), 128'(vt[i].e_s2r));
      end
    end

    // latency / bypass on an empty buffer, with a full-entry layout check
    exp_entry = {6'h2A, 1'b1, 32'hDEADBEEF, 6'd0, 1'b1, 6'd0, 1'b1, 5'd7, 1'b1, 6'd33,
                 1'b1, 32'h12345678, 1'b0};
    @(negedge CLK);
    idle();
    Rename_Valid_IN = 1; Op_IN = 6'h2A; HasImm_IN = 1; Imm_IN = 32'hDEADBEEF; Shift_IN = 5'd7;
    RegWrite_IN = 1; Dest_IN = 6'd33; MemWrite_IN = 1; MemWriteData_IN = 32'h12345678;
    #2;
`ifdef ISSUE_DISPATCH_BYPASS_EN
    chk("bypass_enqueue", 128'(Enqueue_OUT), 128'(1));
    chk("bypass_entry", 128'(IssueQueueEntry_OUT), 128'(exp_entry));
`else
    chk("latency_no_enqueue", 128'(Enqueue_OUT), 128'(0));
`endif
    @(negedge CLK);
    idle();
    #2;
`ifdef ISSUE_DISPATCH_BYPASS_EN
    chk("bypass_not_buffered", 128'(Enqueue_OUT), 128'(0));
`else
    chk("latency_enqueue", 128'(Enqueue_OUT), 128'(1));
    chk("latency_entry", 128'(IssueQueueEntry_OUT), 128'(exp_entry));
`endif

    // dest 33 must now be busy
    @(negedge CLK);
    idle(); Rename_Valid_IN = 1; Op_IN = 6'd1; Src1_IN = 6'd33; IQFull_IN = 1;
    @(negedge CLK);
    idle(); IQFull_IN = 1;
    #2;
    chk("busy33_op", 128'(IssueQueueEntry_OUT[98:93]), 128'(1));
    chk("busy33_src1ready", 128'(IssueQueueEntry_OUT[53]), 128'(0));

    // async reset mid-operation
    @(negedge CLK);
    idle(); Rename_Valid_IN = 1; Op_IN = 6'd2; IQFull_IN = 1;
    @(negedge CLK);
    idle();
    #2;
    chk("pre_reset_enqueue", 128'(Enqueue_OUT), 128'(1));
    #1 RESET = 1'b0;
    #1;
    chk("async_reset_enqueue", 128'(Enqueue_OUT), 128'(0));
    chk("async_reset_ready", 128'(Rename_Ready_OUT), 128'(1));
    chk("async_reset_entry", 128'(IssueQueueEntry_OUT), 128'(0));
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    chk("post_reset_enqueue", 128'(Enqueue_OUT), 128'(0));
    @(negedge CLK);
    idle(); Rename_Valid_IN = 1; Op_IN = 6'd3; Src1_IN = 6'd33; IQFull_IN = 1;
    @(negedge CLK);
    idle();
    #2;
    chk("post_reset_busy_clear", 128'(IssueQueueEntry_OUT[53]), 128'(1));
    chk("post_reset_op", 128'(IssueQueueEntry_OUT[98:93]), 128'(3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
